cond_unit: RTL
==============

Name: cond_unit

Overview:
Consumer end of the ALU-decoder control interface. It takes flag_w and no_write from the ALU decoder, plus the ALU result flags, and holds the architectural NZCV flag register. It evaluates the instruction's 4-bit ARM condition field against the current flags and gates the datapath write enables (register write, memory write, PC write). It sits between the main/ALU decoders and the datapath in the ARM core.

Parameters:
CNT_W, 32, width of the optional performance counters (used only when COND_PERF_CNT_EN is defined)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
en  in  1  cycle enable; 0 = stall
instr_valid  in  1  current instruction is valid this cycle
cond  in  4  instruction bits [31:28]
alu_flags  in  4  ALU result flags {N,Z,C,V}
flag_w  in  2  from ALU decoder; [1] = write N,Z; [0] = write C,V
pcs  in  1  instruction writes PC
reg_w  in  1  instruction writes register file
mem_w  in  1  instruction writes memory
no_write  in  1  from ALU decoder; suppresses register write (CMP/TST)
flags  out  4  current architectural {N,Z,C,V}
cond_ex  out  1  condition passed
undef  out  1  cond == 4'b1111
pc_src  out  1  gated PC write
reg_write  out  1  gated register write
mem_write  out  1  gated memory write
exec_cnt  out  CNT_W  executed-instruction count (feature only)
skip_cnt  out  CNT_W  condition-failed count (feature only)

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: flags <= 4'b0000. While reset is high, pc_src, reg_write and mem_write are forced to 0.
- cond_ex (combinational, from the registered flags, never from alu_flags):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL (1110) = 1; 1111 = 0 with undef=1
- Gating, where g = cond_ex & instr_valid & en & !reset:
  - pc_src = pcs & g
  - reg_write = reg_w & !no_write & g
  - mem_write = mem_w & g
- Flag update at the clock edge, only when g = 1:
  - flag_w[1] = 1: N,Z <= alu_flags[3:2]
  - flag_w[0] = 1: C,V <= alu_flags[1:0]
  - Bits whose write enable is 0 hold their value.
- Update timing:
  - Same-cycle evaluation uses the old flags; new flags are visible on `flags` and cond_ex in the next cycle (one-cycle latency).
  - A condition-failed instruction never modifies flags, even with flag_w = 11.
  - en = 0 freezes flags and counters and forces all gated outputs to 0.
  - instr_valid = 0 has the same effect.
- Reset asserted in the same cycle as a flag write: reset wins, flags = 0.
- flag_w = 11 with no_write = 1 (CMP): flags update; reg_write = 0.

Optional Feature:
- Macro COND_PERF_CNT_EN.
- Defined:
  - exec_cnt increments on each cycle with instr_valid & en & cond_ex.
  - skip_cnt increments on each cycle with instr_valid & en & !cond_ex. This includes undef cycles.
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Not defined: no counter registers exist; exec_cnt and skip_cnt are driven to 0.

Decomposition:
- Shared package cond_pkg holds:
  - enum cond_e (EQ..AL, NV = 4'b1111)
  - flag bit indices N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0
  - FLAGW_NZ=1, FLAGW_CV=0
- One combinational sub-module, cond_check (cond, flags -> cond_ex, undef). It is reused by the multicycle controller.
- The flag register, gating and counters live in cond_unit.

Test Plan:
- Reset, then cond=1110, reg_w=1, instr_valid=1, en=1 → reg_write=1, flags=0000. Repeat with cond=0000 (EQ) → reg_write=0.
- CMP equal: flag_w=11, no_write=1, alu_flags=0110, cond=1110 → reg_write=0 that cycle; next cycle flags=0110 and cond=0000 gives cond_ex=1.
- Partial write: flags=1111, then AND with flag_w=10, alu_flags=0000 → flags=0011.
- Failed condition: flags=0000, cond=0000, flag_w=11, alu_flags=1111, pcs=1, mem_w=1 → pc_src=0, mem_write=0, flags stay 0000.
- GE/LT/GT/LE: sweep all 16 flag values × 16 cond values against a reference model. cond=1111 → cond_ex=0, undef=1.
- Stall and reset: en=0 with a valid flag-writing instruction → flags unchanged, all gated outputs 0. Reset asserted with flag_w=11 → flags=0000. With COND_PERF_CNT_EN: 3 executed + 2 skipped → exec_cnt=3, skip_cnt=2.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared definitions for ARM condition evaluation: condition codes, NZCV bit
// positions and flag_w bit positions.
package cond_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned FLAGW_W = 2;

  localparam int unsigned N_IDX = 3;
  localparam int unsigned Z_IDX = 2;
  localparam int unsigned C_IDX = 1;
  localparam int unsigned V_IDX = 0;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

  typedef enum logic [COND_W-1:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-field evaluator; shared with the multicycle
// controller.
module cond_check
  import cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              cond_ex,
  output logic              undef
);

  logic n, z, c, v;

  assign n = flags[N_IDX];
  assign z = flags[Z_IDX];
  assign c = flags[C_IDX];
  assign v = flags[V_IDX];

  assign undef = (cond_e'(cond) == NV);

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = !z;
      CS: cond_ex = c;
      CC: cond_ex = !c;
      MI: cond_ex = n;
      PL: cond_ex = !n;
      VS: cond_ex = v;
      VC: cond_ex = !v;
      HI: cond_ex = c && !z;
      LS: cond_ex = !c || z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = !z && (n == v);
      LE: cond_ex = z || (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// NZCV flag register, condition gating of datapath write enables.
// Optional exec/skip performance counters under COND_PERF_CNT_EN.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               instr_valid,
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAG_W-1:0]  alu_flags,
  input  logic [FLAGW_W-1:0] flag_w,
  input  logic               pcs,
  input  logic               reg_w,
  input  logic               mem_w,
  input  logic               no_write,
  output logic [FLAG_W-1:0]  flags,
  output logic               cond_ex,
  output logic               undef,
  output logic               pc_src,
  output logic               reg_write,
  output logic               mem_write,
  output logic [CNT_W-1:0]   exec_cnt,
  output logic [CNT_W-1:0]   skip_cnt
);

  logic gate;

  // Evaluated against the registered flags, so a flag write is seen next cycle.
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex),
    .undef   (undef)
  );

  assign gate      = cond_ex && instr_valid && en && !reset;
  assign pc_src    = pcs && gate;
  assign reg_write = reg_w && !no_write && gate;
  assign mem_write = mem_w && gate;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= '0;
    end else if (gate) begin
      if (flag_w[FLAGW_NZ]) begin
        flags[N_IDX] <= alu_flags[N_IDX];
        flags[Z_IDX] <= alu_flags[Z_IDX];
      end
      if (flag_w[FLAGW_CV]) begin
        flags[C_IDX] <= alu_flags[C_IDX];
        flags[V_IDX] <= alu_flags[V_IDX];
      end
    end
  end

`ifdef COND_PERF_CNT_EN
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] skip_q;

  // Undefined (NV) instructions count as skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_q <= '0;
      skip_q <= '0;
    end else if (instr_valid && en) begin
      if (cond_ex) begin
        exec_q <= exec_q + CNT_W'(1);
      end else begin
        skip_q <= skip_q + CNT_W'(1);
      end
    end
  end

  assign exec_cnt = exec_q;
  assign skip_cnt = skip_q;
`else
  assign exec_cnt = '0;
  assign skip_cnt = '0;
`endif

endmodule
